// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : ALU control codes, RV32I opcode/funct constants and encode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] c_alu_add  = 4'd0;
    localparam logic [3:0] c_alu_sub  = 4'd1;
    localparam logic [3:0] c_alu_and  = 4'd2;
    localparam logic [3:0] c_alu_or   = 4'd3;
    localparam logic [3:0] c_alu_xor  = 4'd4;
    localparam logic [3:0] c_alu_sll  = 4'd5;
    localparam logic [3:0] c_alu_srl  = 4'd6;
    localparam logic [3:0] c_alu_sra  = 4'd7;
    localparam logic [3:0] c_alu_slt  = 4'd8;
    localparam logic [3:0] c_alu_sltu = 4'd9;

    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;

    localparam logic [2:0] c_f3_add_sub = 3'b000;
    localparam logic [2:0] c_f3_sll     = 3'b001;
    localparam logic [2:0] c_f3_slt     = 3'b010;
    localparam logic [2:0] c_f3_sltu    = 3'b011;
    localparam logic [2:0] c_f3_xor     = 3'b100;
    localparam logic [2:0] c_f3_srl_sra = 3'b101;
    localparam logic [2:0] c_f3_or      = 3'b110;
    localparam logic [2:0] c_f3_and     = 3'b111;

    localparam logic [6:0] c_f7_base = 7'b0000000;
    localparam logic [6:0] c_f7_alt  = 7'b0100000;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } q_state_t;

    // SUB has no immediate form in RV32I, so SUB with an immediate is rejected.
    function automatic logic alu_illegal(input logic [3:0] op, input logic use_imm);
        return (op > c_alu_sltu) || ((op == c_alu_sub) && use_imm);
    endfunction

    function automatic logic [2:0] alu_funct3(input logic [3:0] op);
        logic [2:0] f3;
        f3 = c_f3_add_sub;
        case (op)
            c_alu_add, c_alu_sub: f3 = c_f3_add_sub;
            c_alu_sll:            f3 = c_f3_sll;
            c_alu_slt:            f3 = c_f3_slt;
            c_alu_sltu:           f3 = c_f3_sltu;
            c_alu_xor:            f3 = c_f3_xor;
            c_alu_srl, c_alu_sra: f3 = c_f3_srl_sra;
            c_alu_or:             f3 = c_f3_or;
            c_alu_and:            f3 = c_f3_and;
            default:              f3 = c_f3_add_sub;
        endcase
        return f3;
    endfunction

    function automatic logic [31:0] alu_encode(
        input logic [3:0]  op,
        input logic        use_imm,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [11:0] imm
    );
        logic [2:0]  f3;
        logic [6:0]  f7_r;
        logic [6:0]  f7_i;
        logic        is_shift;
        logic [31:0] word;
        f3       = alu_funct3(op);
        f7_r     = ((op == c_alu_sub) || (op == c_alu_sra)) ? c_f7_alt : c_f7_base;
        f7_i     = (op == c_alu_sra) ? c_f7_alt : c_f7_base;
        is_shift = (op == c_alu_sll) || (op == c_alu_srl) || (op == c_alu_sra);
        if (!use_imm) begin
            word = {f7_r, rs2, rs1, f3, rd, c_opc_op};
        end else if (is_shift) begin
            // imm[11:5] is replaced by funct7 for immediate shifts
            word = {f7_i, imm[4:0], rs1, f3, rd, c_opc_op_imm};
        end else begin
            word = {imm, rs1, f3, rd, c_opc_op_imm};
        end
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_instr_encoder_if
// Brief    : Request, output-queue, flush and error signals of the encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_instr_encoder_if;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_alu_op;
    logic        req_use_imm;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [11:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;

    modport master (
        output flush, req_valid, req_alu_op, req_use_imm, req_rd, req_rs1,
               req_rs2, req_imm, out_ready,
        input  req_ready, out_valid, out_instr, out_addr, err
    );

    modport slave (
        input  flush, req_valid, req_alu_op, req_use_imm, req_rd, req_rs1,
               req_rs2, req_imm, out_ready,
        output req_ready, out_valid, out_instr, out_addr, err
    );
endinterface
`default_nettype wire

// File: rtl/instr_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : instr_fifo2
// Brief    : Two-entry queue with EMPTY/ONE/FULL state and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fifo2
    import alu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              flush,
    input  wire logic              push,
    input  wire logic              pop,
    input  wire logic [DATA_W-1:0] din,
    output logic      [DATA_W-1:0] dout,
    output logic                   full,
    output logic                   empty
);

    q_state_t          r_state;
    q_state_t          w_state_nxt;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic [DATA_W-1:0] w_head_nxt;
    logic [DATA_W-1:0] w_tail_nxt;
    logic              w_push;
    logic              w_pop;

    assign w_push = push && (r_state != Q_FULL);
    assign w_pop  = pop  && (r_state != Q_EMPTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= Q_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    // Head is always the oldest entry; tail only holds the second one in FULL.
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        if (flush) begin
            w_state_nxt = Q_EMPTY;
        end else begin
            case (r_state)
                Q_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = Q_ONE;
                        w_head_nxt  = din;
                    end
                end
                Q_ONE: begin
                    if (w_push && w_pop) begin
                        w_head_nxt = din;
                    end else if (w_push) begin
                        w_state_nxt = Q_FULL;
                        w_tail_nxt  = din;
                    end else if (w_pop) begin
                        w_state_nxt = Q_EMPTY;
                    end
                end
                Q_FULL: begin
                    if (w_pop) begin
                        w_state_nxt = Q_ONE;
                        w_head_nxt  = r_tail;
                    end
                end
                default: begin
                    w_state_nxt = Q_EMPTY;
                end
            endcase
        end
    end

    assign dout  = r_head;
    assign full  = (r_state == Q_FULL);
    assign empty = (r_state == Q_EMPTY);

endmodule
`default_nettype wire

// File: rtl/alu_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_instr_encoder
// Brief    : Encodes ALU requests into RV32I words with sequential addresses.
// Revision : 1.0 - initial release
// ============================================================================
module alu_instr_encoder
    import alu_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           rst_n,
    alu_instr_encoder_if.slave  bus
);

    localparam int C_DATA_W = 64;

    logic                r_err;
    logic [31:0]         r_addr;
    logic                w_accept;
    logic                w_illegal;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [31:0]         w_instr;
    logic [C_DATA_W-1:0] w_fifo_dout;

    assign w_illegal = alu_illegal(bus.req_alu_op, bus.req_use_imm);
    assign w_instr   = alu_encode(bus.req_alu_op, bus.req_use_imm, bus.req_rd,
                                  bus.req_rs1, bus.req_rs2, bus.req_imm);

    // Ready/valid come from registered queue state only, never from out_ready.
    assign w_accept = bus.req_valid && !w_full;
    assign w_push   = w_accept && !w_illegal && !bus.flush;
    assign w_pop    = bus.out_ready && !w_empty && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_accept && w_illegal && !bus.flush;
            if (bus.flush) begin
                r_addr <= '0;
            end else if (w_push) begin
                r_addr <= r_addr + 32'd4;
            end
        end
    end

    instr_fifo2 #(
        .DATA_W (C_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.flush),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({w_instr, r_addr}),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    assign bus.req_ready = !w_full;
    assign bus.out_valid = !w_empty;
    assign bus.out_instr = w_fifo_dout[63:32];
    assign bus.out_addr  = w_fifo_dout[31:0];
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_instr_encoder
// Brief    : Self-checking bench: vector table, directed sequences, random run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_instr_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_instr_encoder_if bus ();

    alu_instr_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit [31:0] instr;
        bit [31:0] addr;
    } ent_t;

    ent_t      mq[$];
    bit [31:0] m_addr = 0;
    bit        m_err  = 0;

    typedef struct {
        bit [3:0]  op;
        bit        ui;
        bit [4:0]  rd;
        bit [4:0]  rs1;
        bit [4:0]  rs2;
        bit [11:0] imm;
        bit [31:0] exp_instr;
        bit [31:0] exp_addr;
        bit        exp_err;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit ref_illegal(input bit [3:0] op, input bit ui);
        return (op > 9) || (op == 1 && ui);
    endfunction

    // Field placement by arithmetic weights rather than bit concatenation.
    function automatic bit [31:0] ref_encode(input bit [3:0] op, input bit ui,
                                             input bit [31:0] rd, input bit [31:0] rs1,
                                             input bit [31:0] rs2, input bit [31:0] imm);
        int        f3_tab[10];
        bit [31:0] f3;
        bit [31:0] f7;
        bit [31:0] low;
        f3_tab = '{0, 0, 7, 6, 4, 1, 5, 5, 2, 3};
        f3  = (op < 10) ? f3_tab[op] : 0;
        low = rs1 * 32768 + f3 * 4096 + rd * 128;
        if (!ui) begin
            f7 = (op == 1 || op == 7) ? 32 : 0;
            return f7 * 33554432 + rs2 * 1048576 + low + 51;
        end else if (op >= 5 && op <= 7) begin
            f7 = (op == 7) ? 32 : 0;
            return f7 * 33554432 + (imm % 32) * 1048576 + low + 19;
        end
        return imm * 1048576 + low + 19;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ":req_ready"}, bus.req_ready, mq.size() < 2);
        chk({tag, ":out_valid"}, bus.out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk({tag, ":out_instr"}, bus.out_instr, mq[0].instr);
            chk({tag, ":out_addr"}, bus.out_addr, mq[0].addr);
        end
        chk({tag, ":err"}, bus.err, m_err);
    endtask

    // Called at a falling edge; drives one cycle, advances the model, checks.
    task automatic drive_cycle(input string tag, input bit v, input bit [3:0] op,
                               input bit ui, input bit [4:0] rd, input bit [4:0] rs1,
                               input bit [4:0] rs2, input bit [11:0] imm,
                               input bit ordy, input bit fl, output bit acc);
        bit pop;
        bit ill;
        bus.req_valid   = v;
        bus.req_alu_op  = op;
        bus.req_use_imm = ui;
        bus.req_rd      = rd;
        bus.req_rs1     = rs1;
        bus.req_rs2     = rs2;
        bus.req_imm     = imm;
        bus.out_ready   = ordy;
        bus.flush       = fl;
        acc = v && (mq.size() < 2);
        pop = ordy && (mq.size() > 0);
        ill = ref_illegal(op, ui);
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_addr = 0;
            m_err  = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc && !ill) begin
                mq.push_back('{instr: ref_encode(op, ui, rd, rs1, rs2, imm), addr: m_addr});
                m_addr += 4;
            end
            m_err = acc && ill;
        end
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic idle(input string tag, input bit ordy, input bit fl);
        bit acc;
        drive_cycle(tag, 0, 0, 0, 0, 0, 0, 0, ordy, fl, acc);
    endtask

    initial begin
        bit          acc;
        bit          pend;
        bit [31:0]   got[$];
        bit [31:0]   prev;

        vt[0] = '{4'd0, 1'b0, 5'd1,  5'd2,  5'd3,  12'h000, 32'h003100B3, 32'h00, 1'b0};
        vt[1] = '{4'd1, 1'b0, 5'd1,  5'd2,  5'd3,  12'h000, 32'h403100B3, 32'h04, 1'b0};
        vt[2] = '{4'd7, 1'b1, 5'd5,  5'd6,  5'd9,  12'hFE3, 32'h40335293, 32'h08, 1'b0};
        vt[3] = '{4'd0, 1'b1, 5'd1,  5'd0,  5'd7,  12'hFFF, 32'hFFF00093, 32'h0C, 1'b0};
        vt[4] = '{4'd12,1'b0, 5'd1,  5'd2,  5'd3,  12'h000, 32'h0,        32'h0,  1'b1};
        vt[5] = '{4'd1, 1'b1, 5'd1,  5'd2,  5'd3,  12'h005, 32'h0,        32'h0,  1'b1};
        vt[6] = '{4'd4, 1'b0, 5'd31, 5'd31, 5'd31, 12'h000, 32'h01FFCFB3, 32'h10, 1'b0};
        vt[7] = '{4'd9, 1'b1, 5'd2,  5'd3,  5'd0,  12'h800, 32'h8001B113, 32'h14, 1'b0};
        vt[8] = '{4'd5, 1'b1, 5'd1,  5'd1,  5'd4,  12'hFFF, 32'h01F09093, 32'h18, 1'b0};

        bus.flush = 0; bus.req_valid = 0; bus.req_alu_op = 0; bus.req_use_imm = 0;
        bus.req_rd = 0; bus.req_rs1 = 0; bus.req_rs2 = 0; bus.req_imm = 0;
        bus.out_ready = 0;

        // Reset state
        #12;
        chk("rst:req_ready", bus.req_ready, 1);
        chk("rst:out_valid", bus.out_valid, 0);
        chk("rst:err", bus.err, 0);
        chk("rst:out_instr", bus.out_instr, 0);
        chk("rst:out_addr", bus.out_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_rst", 0, 0);
        chk("post_rst:out_instr", bus.out_instr, 0);

        // Vector table: each legal entry lands alone at the head, then is popped
        foreach (vt[i]) begin
            drive_cycle($sformatf("vec%0d", i), 1, vt[i].op, vt[i].ui, vt[i].rd,
                        vt[i].rs1, vt[i].rs2, vt[i].imm, 0, 0, acc);
            chk($sformatf("vec%0d:err", i), bus.err, vt[i].exp_err);
            if (vt[i].exp_err) begin
                chk($sformatf("vec%0d:no_enq", i), bus.out_valid, 0);
                idle($sformatf("vec%0d:err_drop", i), 0, 0);
                chk($sformatf("vec%0d:err_1cyc", i), bus.err, 0);
            end else begin
                chk($sformatf("vec%0d:instr", i), bus.out_instr, vt[i].exp_instr);
                chk($sformatf("vec%0d:addr", i), bus.out_addr, vt[i].exp_addr);
                idle($sformatf("vec%0d:pop", i), 1, 0);
            end
        end

        // Back-pressure: three pushes with the consumer stalled
        idle("bp:flush", 0, 1);
        drive_cycle("bp:p1", 1, 4'd0, 0, 5'd1, 5'd1, 5'd1, 0, 0, 0, acc);
        drive_cycle("bp:p2", 1, 4'd3, 0, 5'd2, 5'd2, 5'd2, 0, 0, 0, acc);
        chk("bp:ready_low", bus.req_ready, 0);
        drive_cycle("bp:p3_stall", 1, 4'd2, 0, 5'd3, 5'd3, 5'd3, 0, 0, 0, acc);
        chk("bp:p3_not_taken", acc, 0);
        pend = 1;
        for (int k = 0; k < 6; k++) begin
            if (bus.out_valid) got.push_back(bus.out_addr);
            drive_cycle("bp:drain", pend, 4'd2, 0, 5'd3, 5'd3, 5'd3, 0, 1, 0, acc);
            if (acc) pend = 0;
        end
        chk("bp:count", got.size(), 3);
        chk("bp:addr0", got[0], 32'h0);
        chk("bp:addr1", got[1], 32'h4);
        chk("bp:addr2", got[2], 32'h8);

        // Illegal request while an entry is held
        drive_cycle("ill:hold", 1, 4'd6, 1, 5'd4, 5'd4, 5'd0, 12'h003, 0, 0, acc);
        drive_cycle("ill:op12", 1, 4'd12, 0, 5'd4, 5'd4, 5'd4, 0, 0, 0, acc);
        chk("ill:err", bus.err, 1);
        chk("ill:head_addr", bus.out_addr, 32'hC);
        drive_cycle("ill:next", 1, 4'd8, 0, 5'd5, 5'd5, 5'd5, 0, 0, 0, acc);
        idle("ill:pop1", 1, 0);
        chk("ill:next_addr", bus.out_addr, 32'h10);
        idle("ill:pop2", 1, 0);

        // Steady push+pop in ONE
        idle("one:flush", 0, 1);
        drive_cycle("one:seed", 1, 4'd0, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, acc);
        prev = bus.out_addr;
        for (int k = 0; k < 10; k++) begin
            drive_cycle("one:pp", 1, 4'($urandom_range(0, 9)), 0, 5'($urandom),
                        5'($urandom), 5'($urandom), 0, 1, 0, acc);
            chk("one:valid", bus.out_valid, 1);
            chk("one:contig", bus.out_addr, prev + 4);
            prev = bus.out_addr;
        end
        idle("one:drain", 1, 0);

        // Address wrap and flush priority
        idle("wrap:flush", 0, 1);
        force dut.r_addr = 32'hFFFF_FFFC;
        #1;
        release dut.r_addr;
        m_addr = 32'hFFFF_FFFC;
        drive_cycle("wrap:p1", 1, 4'd0, 0, 5'd1, 5'd1, 5'd1, 0, 0, 0, acc);
        chk("wrap:addr_top", bus.out_addr, 32'hFFFF_FFFC);
        drive_cycle("wrap:p2", 1, 4'd0, 0, 5'd2, 5'd2, 5'd2, 0, 1, 0, acc);
        chk("wrap:addr_zero", bus.out_addr, 32'h0);
        drive_cycle("wrap:flush_pp", 1, 4'd0, 0, 5'd3, 5'd3, 5'd3, 0, 1, 1, acc);
        chk("wrap:flush_empty", bus.out_valid, 0);
        chk("wrap:flush_err", bus.err, 0);
        drive_cycle("wrap:flush_ill", 1, 4'd13, 0, 5'd3, 5'd3, 5'd3, 0, 0, 1, acc);
        chk("wrap:flush_ill_err", bus.err, 0);
        drive_cycle("wrap:after", 1, 4'd0, 0, 5'd3, 5'd3, 5'd3, 0, 0, 0, acc);
        chk("wrap:after_addr", bus.out_addr, 32'h0);

        // Asynchronous reset with a full queue
        drive_cycle("ar:fill", 1, 4'd0, 0, 5'd4, 5'd4, 5'd4, 0, 0, 0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar:out_valid", bus.out_valid, 0);
        chk("ar:req_ready", bus.req_ready, 1);
        chk("ar:out_addr", bus.out_addr, 0);
        chk("ar:out_instr", bus.out_instr, 0);
        mq.delete();
        m_addr = 0;
        m_err  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle("ar:post", 0, 0);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            bit [3:0] op;
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                              : 4'($urandom_range(0, 9));
            drive_cycle("rnd", $urandom_range(0, 3) != 0, op, 1'($urandom),
                        5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom),
                        $urandom_range(0, 9) < 7, $urandom_range(0, 63) == 0, acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
